mem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single-port unified instruction/data memory between the multi-cycle RISC-V core and a DMA/loader master.
- Sits between the core's memory port and the memory.
- Grants at most one access per cycle and routes 1-cycle-latency read data back to the requester that issued the read.
- Uses round-robin with a bounded burst, so neither master starves the other.

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of the single-port unified memory.
// The multi-cycle core and the DMA/loader share the port; grants are
// combinational, one per cycle, round-robin with a bounded burst so that
// a master holding the port yields after MAX_BURST consecutive grants
// whenever the other master is waiting. Read data has a fixed one-cycle
// latency and is steered back by remembering who issued the read.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4      // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset_n,

  // core master
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [2:0]        core_funct3,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,

  // DMA / loader master
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic [2:0]        dma_funct3,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,

  // memory port
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_ra,
  output logic [ADDR_W-1:0] mem_wa,
  output logic [DATA_W-1:0] mem_wd,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rd
);

  // Who holds (or last held) the port. NONE means the port went idle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  // Four bits cover the whole legal MAX_BURST range.
  localparam int              CNT_W   = 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [2:0]      F3_WORD = 3'b010;

  owner_e           owner_q;
  owner_e           last_winner_q;
  owner_e           rd_owner_q;
  logic [CNT_W-1:0] burst_cnt_q;

  owner_e           winner;

  // Pick this cycle's winner from the live requests and the burst state.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the if/else tree can leave it unassigned and infer a latch.
    winner = OWN_NONE;
    // Nothing is granted while reset is held, so no write can slip into
    // memory during reset even though the grant path is combinational.
    if (!reset_n) begin
      winner = OWN_NONE;
    end else if (core_req && dma_req) begin
      if (owner_q == OWN_NONE) begin
        // Fresh contention: the master that did not win last goes first.
        winner = (last_winner_q == OWN_CORE) ? OWN_DMA : OWN_CORE;
      end else if (burst_cnt_q < MAX_CNT) begin
        winner = owner_q;
      end else begin
        // Burst budget used up: hand the port to the waiting master.
        winner = (owner_q == OWN_CORE) ? OWN_DMA : OWN_CORE;
      end
    end else if (core_req) begin
      winner = OWN_CORE;
    end else if (dma_req) begin
      winner = OWN_DMA;
    end
  end

  assign core_gnt = (winner == OWN_CORE);
  assign dma_gnt  = (winner == OWN_DMA);

  // Route the winner's access to the memory; park the port when idle.
  always_comb begin
    mem_wen    = 1'b0;
    mem_ra     = '0;
    mem_wa     = '0;
    mem_wd     = '0;
    mem_funct3 = F3_WORD;
    unique case (winner)
      OWN_CORE: begin
        mem_wen    = core_we;
        mem_ra     = core_addr;
        mem_wa     = core_addr;
        mem_wd     = core_wdata;
        mem_funct3 = core_funct3;
      end
      OWN_DMA: begin
        mem_wen    = dma_we;
        mem_ra     = dma_addr;
        mem_wa     = dma_addr;
        mem_wd     = dma_wdata;
        mem_funct3 = dma_funct3;
      end
      default: ;
    endcase
  end

  // Track ownership, burst length, tie-break history and pending read.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      owner_q       <= OWN_NONE;
      last_winner_q <= OWN_DMA;      // core wins the first tie
      burst_cnt_q   <= '0;
      rd_owner_q    <= OWN_NONE;     // drops any read in flight
    end else if (winner == OWN_NONE) begin
      // Only reachable with both requests low: the port goes idle and the
      // next contention starts from the tie-break rule.
      owner_q     <= OWN_NONE;
      burst_cnt_q <= '0;
      rd_owner_q  <= OWN_NONE;
    end else begin
      if (winner == owner_q) begin
        if (burst_cnt_q != MAX_CNT) begin
          burst_cnt_q <= burst_cnt_q + CNT_W'(1);
        end
      end else begin
        owner_q     <= winner;
        burst_cnt_q <= CNT_W'(1);
      end
      last_winner_q <= winner;
      rd_owner_q    <= mem_wen ? OWN_NONE : winner;
    end
  end

  // rd_owner_q is a register, so both rvalids come straight off a flop.
  assign core_rvalid = (rd_owner_q == OWN_CORE);
  assign dma_rvalid  = (rd_owner_q == OWN_DMA);

  // Read data fans out to both masters; rvalid says whose it is.
  assign core_rdata = mem_rd;
  assign dma_rdata  = mem_rd;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomised checks for mem_arbiter.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge, mid-cycle.
module tb_mem_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  logic              clk;
  logic              reset_n;
  logic              core_req, core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [2:0]        core_funct3;
  logic              core_gnt, core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              dma_req, dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [2:0]        dma_funct3;
  logic              dma_gnt, dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_ra, mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [2:0]        mem_funct3;
  logic [DATA_W-1:0] mem_rd;

  int tests  = 0;
  int failed = 0;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_funct3(core_funct3),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_funct3(dma_funct3),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_wen(mem_wen), .mem_ra(mem_ra), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .mem_funct3(mem_funct3), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- drive helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_funct3 = 3'b010;
    dma_req  = 0; dma_we  = 0; dma_addr  = '0; dma_wdata  = '0; dma_funct3  = 3'b010;
    mem_rd   = '0;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // 2-bit encoding used by the bench: 0 none, 1 core, 2 dma
  function automatic int observed_winner();
    if (core_gnt && dma_gnt) return 3;
    if (core_gnt) return 1;
    if (dma_gnt)  return 2;
    return 0;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    tests++;
    if ({core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_wen} !== 5'b0) begin
      failed++;
      $display("FAIL reset_ctrl: gnt/rvalid/wen=%b expected 00000",
               {core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_wen});
    end
    tests++;
    if (mem_funct3 !== 3'b010 || mem_ra !== '0 || mem_wd !== '0) begin
      failed++;
      $display("FAIL reset_idle_port: funct3=%b ra=%h wd=%h expected 010 0 0",
               mem_funct3, mem_ra, mem_wd);
    end
  endtask

  task automatic test_core_read();
    reset_dut();
    core_req = 1; core_we = 0; core_addr = 32'h100; core_funct3 = 3'b100;
    @(negedge clk);
    tests++;
    if (core_gnt !== 1'b1 || dma_gnt !== 1'b0 || mem_ra !== 32'h100 ||
        mem_wen !== 1'b0 || mem_funct3 !== 3'b100) begin
      failed++;
      $display("FAIL core_read_gnt: gnt=%b/%b ra=%h wen=%b f3=%b expected 1/0 100 0 100",
               core_gnt, dma_gnt, mem_ra, mem_wen, mem_funct3);
    end
    tick();
    core_req = 0;
    mem_rd = 32'hDEAD_BEEF;
    @(negedge clk);
    tests++;
    if (core_rvalid !== 1'b1 || core_rdata !== 32'hDEAD_BEEF || dma_rvalid !== 1'b0) begin
      failed++;
      $display("FAIL core_read_data: rvalid=%b rdata=%h dma_rvalid=%b expected 1 deadbeef 0",
               core_rvalid, core_rdata, dma_rvalid);
    end
    tick();
    @(negedge clk);
    tests++;
    if (core_rvalid !== 1'b0) begin
      failed++;
      $display("FAIL core_read_single: rvalid=%b expected 0", core_rvalid);
    end
  endtask

  task automatic test_dma_write();
    reset_dut();
    dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h55; dma_funct3 = 3'b010;
    @(negedge clk);
    tests++;
    if (dma_gnt !== 1'b1 || core_gnt !== 1'b0 || mem_wen !== 1'b1 ||
        mem_wa !== 32'h40 || mem_wd !== 32'h55) begin
      failed++;
      $display("FAIL dma_write: gnt=%b wen=%b wa=%h wd=%h expected 1 1 40 55",
               dma_gnt, mem_wen, mem_wa, mem_wd);
    end
    tick();
    dma_req = 0; dma_we = 0;
    @(negedge clk);
    tests++;
    if (dma_rvalid !== 1'b0 || core_rvalid !== 1'b0 || mem_wen !== 1'b0) begin
      failed++;
      $display("FAIL dma_write_no_rvalid: rvalid=%b/%b wen=%b expected 0/0 0",
               core_rvalid, dma_rvalid, mem_wen);
    end
  endtask

  task automatic test_rr_burst();
    int exp_seq [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};
    reset_dut();
    core_req = 1; core_we = 0; core_addr = 32'hC0; core_funct3 = 3'b001;
    dma_req  = 1; dma_we  = 0; dma_addr  = 32'hD0; dma_funct3  = 3'b101;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tests++;
      if (observed_winner() !== exp_seq[i] ||
          mem_ra !== ((exp_seq[i] == 1) ? 32'hC0 : 32'hD0) ||
          mem_funct3 !== ((exp_seq[i] == 1) ? 3'b001 : 3'b101)) begin
        failed++;
        $display("FAIL rr_burst[%0d]: winner=%0d ra=%h f3=%b expected winner %0d",
                 i, observed_winner(), mem_ra, mem_funct3, exp_seq[i]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_alternating();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin core_req = 1; core_addr = 32'h200 + i; end
      else            begin dma_req  = 1; dma_addr  = 32'h300 + i; end
      @(negedge clk);
      tests++;
      if (observed_winner() !== ((i % 2 == 0) ? 1 : 2)) begin
        failed++;
        $display("FAIL alternating[%0d]: winner=%0d expected %0d",
                 i, observed_winner(), (i % 2 == 0) ? 1 : 2);
      end
      tick();
      core_req = 0; dma_req = 0;
      @(negedge clk);
      tests++;
      if (observed_winner() !== 0) begin
        failed++;
        $display("FAIL alternating_idle[%0d]: winner=%0d expected 0", i, observed_winner());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_read();
    reset_dut();
    core_req = 1; core_we = 0; core_addr = 32'h80;
    @(negedge clk);
    tests++;
    if (core_gnt !== 1'b1) begin
      failed++;
      $display("FAIL midrst_gnt: core_gnt=%b expected 1", core_gnt);
    end
    tick();
    // Reset lands in the rvalid cycle; a write request is pending throughout.
    reset_n = 0;
    core_req = 0;
    dma_req = 1; dma_we = 1; dma_addr = 32'h44; dma_wdata = 32'h1234;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (mem_wen !== 1'b0 || core_gnt !== 1'b0 || dma_gnt !== 1'b0) begin
        failed++;
        $display("FAIL midrst_quiet[%0d]: wen=%b gnt=%b/%b expected 0 0/0",
                 i, mem_wen, core_gnt, dma_gnt);
      end
      tick();
    end
    reset_n = 1;
    dma_req = 0; dma_we = 0;
    @(negedge clk);
    tests++;
    if (core_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
      failed++;
      $display("FAIL midrst_rvalid: rvalid=%b/%b expected 0/0", core_rvalid, dma_rvalid);
    end
    tick();
    // Owner back to NONE with last winner DMA: the core takes a fresh tie.
    core_req = 1; dma_req = 1;
    @(negedge clk);
    tests++;
    if (observed_winner() !== 1) begin
      failed++;
      $display("FAIL midrst_tie: winner=%0d expected 1", observed_winner());
    end
    tick();
    idle_inputs();
  endtask

  // Reference behaviour for the random run.
  int m_owner, m_last, m_cnt;

  function automatic int model_pick(bit c, bit d);
    if (c && d) begin
      if (m_owner == 0)        return (m_last == 1) ? 2 : 1;
      if (m_cnt < MAX_BURST)   return m_owner;
      return 3 - m_owner;
    end
    if (c) return 1;
    if (d) return 2;
    return 0;
  endfunction

  task automatic test_random();
    int exp_w, exp_rv, c_wait, d_wait;
    bit c_done, d_done;
    reset_dut();
    m_owner = 0; m_last = 2; m_cnt = 0;
    exp_rv = 0; c_wait = 0; d_wait = 0; c_done = 0; d_done = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (c_done) core_req = 0;
      if (d_done) dma_req  = 0;
      if (!core_req && $urandom_range(0, 2) != 0) begin
        core_req = 1; core_we = 1'($urandom_range(0, 1)); core_addr = $urandom;
        core_wdata = $urandom; core_funct3 = 3'($urandom_range(0, 7));
      end
      if (!dma_req && $urandom_range(0, 2) != 0) begin
        dma_req = 1; dma_we = 1'($urandom_range(0, 1)); dma_addr = $urandom;
        dma_wdata = $urandom; dma_funct3 = 3'($urandom_range(0, 7));
      end
      mem_rd = $urandom;
      @(negedge clk);
      exp_w = model_pick(core_req, dma_req);
      tests++;
      if (observed_winner() !== exp_w) begin
        failed++;
        $display("FAIL rand_gnt@%0d: winner=%0d expected %0d", cyc, observed_winner(), exp_w);
      end
      tests++;
      if (core_rvalid !== (exp_rv == 1) || dma_rvalid !== (exp_rv == 2) ||
          (core_rvalid && core_rdata !== mem_rd) || (dma_rvalid && dma_rdata !== mem_rd)) begin
        failed++;
        $display("FAIL rand_rvalid@%0d: rvalid=%b/%b expected owner %0d",
                 cyc, core_rvalid, dma_rvalid, exp_rv);
      end
      if (exp_w == 1 || exp_w == 2) begin
        tests++;
        if (mem_wen !== ((exp_w == 1) ? core_we : dma_we) ||
            mem_ra  !== ((exp_w == 1) ? core_addr : dma_addr) ||
            mem_wa  !== ((exp_w == 1) ? core_addr : dma_addr) ||
            mem_wd  !== ((exp_w == 1) ? core_wdata : dma_wdata) ||
            mem_funct3 !== ((exp_w == 1) ? core_funct3 : dma_funct3)) begin
          failed++;
          $display("FAIL rand_port@%0d: wen=%b ra=%h wa=%h wd=%h f3=%b for winner %0d",
                   cyc, mem_wen, mem_ra, mem_wa, mem_wd, mem_funct3, exp_w);
        end
      end else begin
        tests++;
        if (mem_wen !== 1'b0) begin
          failed++;
          $display("FAIL rand_wen_idle@%0d: wen=%b expected 0", cyc, mem_wen);
        end
      end
      c_wait = (core_req && !core_gnt) ? c_wait + 1 : 0;
      d_wait = (dma_req  && !dma_gnt)  ? d_wait + 1 : 0;
      tests++;
      if (c_wait > MAX_BURST || d_wait > MAX_BURST) begin
        failed++;
        $display("FAIL rand_starve@%0d: waits core=%0d dma=%0d limit %0d",
                 cyc, c_wait, d_wait, MAX_BURST);
      end
      // advance the model past this edge
      if (exp_w == 0) begin
        if (!core_req && !dma_req) begin m_owner = 0; m_cnt = 0; end
        exp_rv = 0;
      end else begin
        if (exp_w == m_owner) begin
          if (m_cnt < MAX_BURST) m_cnt++;
        end else begin
          m_owner = exp_w; m_cnt = 1;
        end
        m_last = exp_w;
        exp_rv = ((exp_w == 1) ? core_we : dma_we) ? 0 : exp_w;
      end
      c_done = (exp_w == 1);
      d_done = (exp_w == 2);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_core_read();
    test_dma_write();
    test_rr_burst();
    test_alternating();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
